// File: rtl/pipelined_logic_gate.sv
// Bitwise N-input logic gate with a single registered output stage and
// valid/ready handshakes on both sides; counts output transfers.

module pipelined_logic_gate_lane #(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0] bits,
    input  logic [2:0]        op,
    output logic              res
);
    always_comb begin
        res = 1'b0;
        unique case (op)
            3'b000:  res = &bits;
            3'b001:  res = |bits;
            3'b010:  res = ^bits;
            3'b011:  res = ~&bits;
            3'b100:  res = ~|bits;
            3'b101:  res = ~^bits;
            3'b110:  res = bits[0];
            default: res = 1'b0;
        endcase
    end
endmodule

module pipelined_logic_gate #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [15:0]             xact_cnt,
    output logic                    op_err
);
    // Bit b of every operand is gathered into one lane so each lane reduces NUM_IN bits.
    logic [WIDTH-1:0][NUM_IN-1:0] lane_bits;
    logic [WIDTH-1:0]             res;
    logic                         in_xfer;
    logic                         out_xfer;

    genvar b, k;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_lane
            for (k = 0; k < NUM_IN; k++) begin : g_op
                assign lane_bits[b][k] = in_data[k*WIDTH + b];
            end
            pipelined_logic_gate_lane #(.NUM_IN(NUM_IN)) u_lane (
                .bits (lane_bits[b]),
                .op   (op),
                .res  (res[b])
            );
        end
    endgenerate

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // A new accept takes priority, which also covers the simultaneous in/out transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= res;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xact_cnt <= '0;
            op_err   <= 1'b0;
        end else begin
            if (out_xfer)
                xact_cnt <= xact_cnt + 16'd1;
            if (in_xfer && op == 3'b111)
                op_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipelined_logic_gate.sv
// Directed-vector bench for pipelined_logic_gate (WIDTH=8, NUM_IN=4).

module tb_pipelined_logic_gate;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] xact_cnt;
    logic        op_err;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pipelined_logic_gate #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xact_cnt  (xact_cnt),
        .op_err    (op_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [2:0] o, input logic [31:0] d);
        in_valid = 1'b1;
        op       = o;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] VA = {8'h0F, 8'h07, 8'h03, 8'h01};
    localparam logic [31:0] VB = {8'hFF, 8'h3C, 8'hF0, 8'hFF};

    logic [7:0] exp_a [0:6];
    logic [7:0] held;

    initial begin
        exp_a[0] = 8'h01; exp_a[1] = 8'h0F; exp_a[2] = 8'h0A; exp_a[3] = 8'hFE;
        exp_a[4] = 8'hF0; exp_a[5] = 8'hF5; exp_a[6] = 8'h01;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; op = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_xact_cnt", xact_cnt, 0);
        chk("rst_op_err", op_err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // AND of FF,F0,3C,FF accepted on the first edge out of reset
        send(3'b000, VB);
        chk("and_valid", out_valid, 1);
        chk("and_data", out_data, 8'h30);
        chk("and_cnt_before", xact_cnt, 0);
        @(negedge clk);
        exp_cnt++;
        chk("and_cnt_after", xact_cnt, exp_cnt);
        chk("and_valid_clr", out_valid, 0);

        for (int i = 0; i < 7; i++) begin
            send(i[2:0], VA);
            chk($sformatf("op%0d_data", i), out_data, exp_a[i]);
            @(negedge clk);
            exp_cnt++;
        end
        chk("ops_cnt", xact_cnt, exp_cnt);

        // Backpressure: result held while downstream stalls
        out_ready = 1'b0;
        send(3'b001, VA);
        chk("bp_valid", out_valid, 1);
        held = out_data;
        chk("bp_first", held, 8'h0F);
        in_valid = 1'b1; op = 3'b000; in_data = VB;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_%0d", i), in_ready, 0);
            chk($sformatf("bp_hold_%0d", i), out_data, held);
            chk($sformatf("bp_vld_%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        in_valid = 1'b0;
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_data", out_data, 8'h30);
        @(negedge clk);
        exp_cnt++;
        chk("bp_drain_valid", out_valid, 0);
        chk("bp_cnt", xact_cnt, exp_cnt);

        // 10 back-to-back pass-through transactions
        in_valid = 1'b1; op = 3'b110;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                chk($sformatf("b2b_vld_%0d", i), out_valid, 1);
                chk($sformatf("b2b_data_%0d", i), out_data, i);
            end
            in_data = {24'h0, 8'(i + 1)};
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_last", out_data, 8'd10);
        @(negedge clk);
        exp_cnt += 10;
        chk("b2b_idle", out_valid, 0);
        chk("b2b_cnt", xact_cnt, exp_cnt);

        // Illegal op: zero result, sticky error flag
        send(3'b111, VA);
        chk("ill_data", out_data, 8'h00);
        chk("ill_err", op_err, 1);
        @(negedge clk);
        send(3'b000, VA);
        chk("ill_next_data", out_data, 8'h01);
        chk("ill_sticky", op_err, 1);
        @(negedge clk);

        // Async reset with a stalled result pending
        out_ready = 1'b0;
        send(3'b010, VA);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_cnt", xact_cnt, 0);
        chk("arst_err", op_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // 65536 output transfers wrap the counter to zero
        in_valid = 1'b1; op = 3'b000; in_data = VB;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        chk("wrap_ffff", xact_cnt, 16'hFFFF);
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_zero", xact_cnt, 16'h0000);
        chk("wrap_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_logic_gate.md
PIPELINED_LOGIC_GATE -- requirements
Module: pipelined_logic_gate

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each operand and of the result (legal 1..64).
REQ-002 SHALL have parameter NUM_IN, default 4, number of operands per transaction (legal 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream offers a transaction.
REQ-006 SHALL have port in_ready  output  1  block accepts a transaction this cycle.
REQ-007 SHALL have port in_data  input  NUM_IN*WIDTH  operand k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port op  input  3  operation select, sampled with in_data.
REQ-009 SHALL have port out_valid  output  1  result register holds a valid result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  registered result.
REQ-012 SHALL have port xact_cnt  output  16  count of completed output handshakes.
REQ-013 SHALL have port op_err  output  1  sticky flag: an illegal op was accepted.

Function
REQ-014 SHALL decode op: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 pass operand 0, 111 illegal.
REQ-015 SHALL compute bitwise across all NUM_IN operands; XOR = odd parity per bit, XNOR = its complement, NAND/NOR = complement of AND/OR.
REQ-016 SHALL produce result 0 for op=111 and set op_err on that accept.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-018 SHALL define input transfer as in_valid && in_ready at a rising edge; output transfer as out_valid && out_ready.
REQ-019 SHALL load out_data and set out_valid on the edge following an input transfer (latency 1 cycle).
REQ-020 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on an output transfer with no simultaneous input transfer.
REQ-022 SHALL, on simultaneous input and output transfer, keep out_valid=1 and load the new result (full throughput, one result per cycle).
REQ-023 SHALL ignore in_data/op when no input transfer occurs; out_data unchanged.
REQ-024 SHALL increment xact_cnt by 1 per output transfer, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL keep op_err set once set until reset; legal ops never clear it.

Reset
REQ-026 SHALL, on rst_n low, immediately (asynchronously) force out_valid=0, out_data=0, xact_cnt=0, op_err=0.
REQ-027 SHALL discard any held result when reset asserts mid-transaction; no output transfer counted.
REQ-028 SHALL accept a transaction on the first rising edge with rst_n high (in_ready=1 since out_valid=0).

Verification
REQ-029 SHALL cover: WIDTH=8, NUM_IN=4, op=000, operands FF,F0,3C,FF, out_ready=1 -> next cycle out_valid=1, out_data=0x30, then xact_cnt=1.
REQ-030 SHALL cover: op=010, operands 01,03,07,0F -> out_data=0x0A; op=101 same operands -> 0xF5.
REQ-031 SHALL cover: out_ready=0 after one accept, in_valid held -> in_ready=0, out_data stable for 5 cycles; out_ready=1 -> next result loaded same edge, out_valid stays 1.
REQ-032 SHALL cover: 10 back-to-back transactions with out_ready=1 -> 10 results on 10 consecutive cycles, xact_cnt=10.
REQ-033 SHALL cover: op=111 accepted -> out_data=0x00, op_err=1, remains 1 after subsequent legal ops.
REQ-034 SHALL cover: rst_n low while out_valid=1 and out_ready=0 -> out_valid, xact_cnt, op_err all 0 before next clock edge; 65536 output transfers after reset -> xact_cnt=0x0000.
